// File: rtl/enc_rev_counter_if.sv
// Bus bundle for enc_rev_counter: clear, raw encoder inputs and packed
// per-channel position/revolution/direction/error outputs.
interface enc_rev_counter_if #(
  parameter int N_CH  = 2,
  parameter int N_ENC = 400,
  parameter int REV_W = 8
);
  localparam int POS_W = $clog2(N_ENC);

  logic                    clr;
  logic [N_CH-1:0]         enc_a;
  logic [N_CH-1:0]         enc_b;
  logic [N_CH*POS_W-1:0]   pos;
  logic [N_CH*REV_W-1:0]   rev;
  logic [N_CH-1:0]         idir;
  logic [7:0]              lport;
  logic [N_CH-1:0]         err;

  modport master (
    output clr, enc_a, enc_b,
    input  pos, rev, idir, lport, err
  );

  modport slave (
    input  clr, enc_a, enc_b,
    output pos, rev, idir, lport, err
  );
endinterface

// File: rtl/enc_rev_counter.sv
// Multi-channel encoder position/revolution counter (step/dir or quadrature x4).
// Define ENC_REV_ERR_EN to compile in sticky illegal-transition flags.
module enc_rev_counter #(
  parameter int N_CH  = 2,
  parameter int N_ENC = 400,
  parameter int REV_W = 8,
  parameter int MODE  = 0
) (
  input  logic            clk,
  input  logic            rst,
  enc_rev_counter_if.slave bus
);
  localparam int POS_W = $clog2(N_ENC);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_ENC - 1);

  typedef enum logic [1:0] {ARM0, ARM1, ARM2, RUN} arm_t;

  arm_t              arm_q;
  logic [N_CH-1:0]   a_s1, a_s2, a_p;
  logic [N_CH-1:0]   b_s1, b_s2, b_p;
  logic [POS_W-1:0]  pos_q [N_CH];
  logic [REV_W-1:0]  rev_q [N_CH];
  logic [N_CH-1:0]   idir_q;
  logic [N_CH-1:0]   up, dn;
  logic              armed;

  assign armed = (arm_q == RUN);

  always_comb begin
    up = '0;
    dn = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (MODE == 0) begin
        if (a_s2[i] && !a_p[i]) begin
          up[i] = b_s2[i];
          dn[i] = !b_s2[i];
        end
      end else begin
        // {prev A, prev B, cur A, cur B}; double changes fall to default
        case ({a_p[i], b_p[i], a_s2[i], b_s2[i]})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: up[i] = 1'b1;
          4'b0100, 4'b1101, 4'b1011, 4'b0010: dn[i] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q  <= ARM0;
      a_s1   <= '0;
      a_s2   <= '0;
      a_p    <= '0;
      b_s1   <= '0;
      b_s2   <= '0;
      b_p    <= '0;
      idir_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        pos_q[i] <= '0;
        rev_q[i] <= '0;
      end
    end else begin
      a_s1 <= bus.enc_a;
      a_s2 <= a_s1;
      b_s1 <= bus.enc_b;
      b_s2 <= b_s1;
      // previous value keeps tracking while disarmed so static inputs never count
      a_p  <= a_s2;
      b_p  <= b_s2;
      case (arm_q)
        ARM0:    arm_q <= ARM1;
        ARM1:    arm_q <= ARM2;
        default: arm_q <= RUN;
      endcase
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (bus.clr) begin
          pos_q[i] <= '0;
          rev_q[i] <= '0;
        end else if (armed && up[i]) begin
          idir_q[i] <= 1'b1;
          if (pos_q[i] == POS_MAX) begin
            pos_q[i] <= '0;
            rev_q[i] <= rev_q[i] + REV_W'(1);
          end else begin
            pos_q[i] <= pos_q[i] + POS_W'(1);
          end
        end else if (armed && dn[i]) begin
          idir_q[i] <= 1'b0;
          if (pos_q[i] == '0) begin
            pos_q[i] <= POS_MAX;
            rev_q[i] <= rev_q[i] - REV_W'(1);
          end else begin
            pos_q[i] <= pos_q[i] - POS_W'(1);
          end
        end
      end
    end
  end

`ifdef ENC_REV_ERR_EN
  logic [N_CH-1:0] bad;
  logic [N_CH-1:0] err_q;

  always_comb begin
    bad = '0;
    if (MODE != 0)
      bad = (a_p ^ a_s2) & (b_p ^ b_s2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= '0;
    else if (bus.clr)
      err_q <= '0;
    else if (armed)
      err_q <= err_q | bad;
  end

  assign bus.err = err_q;
`else
  assign bus.err = '0;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign bus.pos[g*POS_W +: POS_W] = pos_q[g];
    assign bus.rev[g*REV_W +: REV_W] = rev_q[g];
  end

  assign bus.idir  = idir_q;
  assign bus.lport = rev_q[0][7:0];
endmodule

// File: doc/enc_rev_counter.md
ENC_REV_COUNTER -- requirements
Module: enc_rev_counter

Interface
REQ-001 Parameter N_CH, default 2: number of independent encoder channels, 1..8.
REQ-002 Parameter N_ENC, default 400: encoder counts per revolution, 2..2048; POS_W = clog2(N_ENC).
REQ-003 Parameter REV_W, default 8: revolution counter width, 8..16.
REQ-004 Parameter MODE, default 0: 0 = step/dir input (A pulse, B direction), 1 = quadrature x4.
REQ-005 CLK  in  1  sole clock; all state on rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 CLR  in  1  synchronous clear of all positions, revolutions, error flags.
REQ-008 ENC_A  in  N_CH  channel A per channel, asynchronous to CLK.
REQ-009 ENC_B  in  N_CH  channel B per channel, asynchronous to CLK.
REQ-010 POS  out  N_CH*POS_W  packed in-revolution position, channel 0 in LSBs.
REQ-011 REV  out  N_CH*REV_W  packed revolution count, two's complement, channel 0 in LSBs.
REQ-012 IDIR  out  N_CH  last counted direction per channel, 1 = up.
REQ-013 LPORT  out  8  REV[7:0] of channel 0, for LED display.
REQ-014 ERR  out  N_CH  sticky illegal-transition flag per channel.

Function
REQ-015 Each ENC_A/ENC_B bit SHALL pass a 2-flop synchroniser; decode SHALL compare synchronised value with a registered previous value.
REQ-016 Input change SHALL be reflected on POS/REV/IDIR after the 3rd rising CLK edge following the change; no other latency.
REQ-017 MODE 0: count SHALL occur on each synchronised rising edge of A; B=1 up, B=0 down; B sampled from same synchroniser stage as A.
REQ-018 MODE 1: AB sequence 00->01->11->10->00 SHALL count up, reverse sequence down, unchanged AB SHALL hold.
REQ-019 MODE 1: both bits changing in one cycle SHALL not count and SHALL set ERR for that channel.
REQ-020 Up at POS=N_ENC-1 SHALL give POS=0 and REV+1; otherwise POS+1, REV held.
REQ-021 Down at POS=0 SHALL give POS=N_ENC-1 and REV-1; otherwise POS-1, REV held.
REQ-022 REV SHALL wrap modulo 2^REV_W in both directions with no saturation flag.
REQ-023 IDIR SHALL update only on a counted event; held otherwise.
REQ-024 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be counted in the same cycle.
REQ-025 CLR SHALL take priority over a coincident count: POS=0, REV=0, ERR=0 next edge; IDIR held; synchronisers not cleared.
REQ-026 ERR SHALL remain set until CLR or RST; a new error in the CLR cycle SHALL be discarded.

Reset
REQ-027 RST SHALL asynchronously force POS=0, REV=0, IDIR=0, ERR=0, LPORT=0, synchroniser and previous-value flops=0.
REQ-028 Decode SHALL be suppressed for the first 3 CLK edges after RST deassertion so that static inputs produce no count or error.
REQ-029 RST asserted mid-count SHALL abort any pending event with no partial update.

Configuration
REQ-030 Macro ENC_REV_ERR_EN defined: ERR detection per REQ-019/026 compiled in.
REQ-031 ENC_REV_ERR_EN undefined: ERR SHALL be tied 0, illegal transitions silently ignored (no count), no error flops.

Verification
REQ-032 MODE 0, N_ENC=400: 400 A pulses with B=1 -> POS=0, REV=1, LPORT=0x01, IDIR=1.
REQ-033 MODE 0: from reset, 1 A pulse with B=0 -> POS=399, REV=0xFF, LPORT=0xFF, IDIR=0.
REQ-034 MODE 1: one full forward Gray cycle (4 transitions) -> POS=4; one reverse cycle -> POS=0; AB 00->11 -> POS unchanged, ERR[ch]=1 (macro defined) / 0 (undefined).
REQ-035 N_CH=2: coincident up on ch0 and down on ch1 at POS=0 -> ch0 POS=1, ch1 POS=N_ENC-1, ch1 REV=-1.
REQ-036 CLR asserted in cycle of a counted edge with POS=5 -> POS=0, REV=0, ERR=0; RST released with A=B=1 held -> no count for 3+ cycles.
